// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor: debounce/decode a 7-seg bus and check 0-9 ordering; period counter built only with SEG7_MON_PERIOD_EN
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          segments,
  input  logic                clear,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                blank,
  output logic                digit_strobe,
  output logic                seq_error,
  output logic                bad_pattern,
  output logic [PERIOD_W-1:0] period
);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] SPRE = SW'(STABLE_CYCLES - 1);
  logic [6:0] s_q, cand, accepted;
  logic [SW-1:0] stab;
  logic have_prev, acc;
  logic [4:0] dec;
  logic [3:0] nxt;
  // acceptance fires on the edge where stab reaches its threshold
  always_comb begin
    acc = s_q == cand && stab == SPRE && cand != accepted;
    nxt = digit == 4'd9 ? 4'd0 : digit + 4'd1;
    dec = 5'h00;
    case (cand)
      7'h3F: dec = 5'h10;
      7'h06: dec = 5'h11;
      7'h5B: dec = 5'h12;
      7'h4F: dec = 5'h13;
      7'h66: dec = 5'h14;
      7'h6D: dec = 5'h15;
      7'h7D: dec = 5'h16;
      7'h07: dec = 5'h17;
      7'h7F: dec = 5'h18;
      7'h6F: dec = 5'h19;
      default: dec = 5'h00;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
      cand <= '0;
      accepted <= '0;
      stab <= '0;
      have_prev <= 1'b0;
      digit <= '0;
      digit_valid <= 1'b0;
      blank <= 1'b0;
      digit_strobe <= 1'b0;
      seq_error <= 1'b0;
      bad_pattern <= 1'b0;
    end else begin
      s_q <= segments;
      cand <= s_q;
      stab <= s_q != cand ? '0 : stab == SMAX ? stab : stab + SW'(1);
      digit_strobe <= acc;
      if (clear) begin
        seq_error <= 1'b0;
        bad_pattern <= 1'b0;
      end
      if (acc) begin
        accepted <= cand;
        digit_valid <= dec[4];
        blank <= cand == 7'h00;
        have_prev <= dec[4];
        if (dec[4]) digit <= dec[3:0];
        if (dec[4] && have_prev && dec[3:0] != nxt) seq_error <= 1'b1;
        if (!dec[4] && cand != 7'h00) bad_pattern <= 1'b1;
      end
    end
  end
`ifdef SEG7_MON_PERIOD_EN
  logic [PERIOD_W-1:0] cyc;
  logic started;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc <= '0;
      started <= 1'b0;
      period <= '0;
    end else if (acc) begin
      cyc <= PERIOD_W'(1);
      started <= 1'b1;
      if (started) period <= cyc;
    end else if (cyc != '1) begin
      cyc <= cyc + PERIOD_W'(1);
    end
  end
`else
  assign period = '0;
`endif
endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb_seven_segment_monitor: directed checks of debounce, decode, ordering, clear and reset
module tb_seven_segment_monitor;
  logic clk = 1'b0;
  logic rst_n, clear;
  logic [6:0] segments;
  logic [3:0] digit;
  logic digit_valid, blank, digit_strobe, seq_error, bad_pattern;
  logic [23:0] period;
  int n_chk = 0;
  int n_fail = 0;
  int st_cnt = 0;
`ifdef SEG7_MON_PERIOD_EN
  localparam int EXP_PERIOD = 20;
`else
  localparam int EXP_PERIOD = 0;
`endif
  seven_segment_monitor #(.STABLE_CYCLES(4), .PERIOD_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .segments(segments), .clear(clear),
    .digit(digit), .digit_valid(digit_valid), .blank(blank),
    .digit_strobe(digit_strobe), .seq_error(seq_error),
    .bad_pattern(bad_pattern), .period(period)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (digit_strobe) st_cnt++;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hold(input logic [6:0] v, input int n);
    segments = v;
    cyc(n);
  endtask
  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    segments = 7'h7F;
    cyc(3);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_strobe", 32'(digit_strobe), 0);
    chk("rst_seq", 32'(seq_error), 0);
    chk("rst_bad", 32'(bad_pattern), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_nostrobe", 32'(st_cnt), 0);
    rst_n = 1'b1;
    hold(7'h3F, 5);
    chk("d0_early", 32'(digit_strobe), 0);
    cyc(1);
    chk("d0_strobe", 32'(digit_strobe), 1);
    chk("d0_digit", 32'(digit), 0);
    chk("d0_valid", 32'(digit_valid), 1);
    chk("d0_period", 32'(period), 0);
    cyc(14);
    hold(7'h06, 6);
    chk("d1_strobe", 32'(digit_strobe), 1);
    chk("d1_digit", 32'(digit), 1);
    chk("d1_seq", 32'(seq_error), 0);
    chk("d1_period", 32'(period), 32'(EXP_PERIOD));
    cyc(14);
    chk("d1_count", 32'(st_cnt), 2);
    hold(7'h5B, 4);
    hold(7'h06, 10);
    chk("glitch_count", 32'(st_cnt), 2);
    chk("glitch_digit", 32'(digit), 1);
    hold(7'h5B, 5);
    hold(7'h4F, 1);
    chk("min_strobe", 32'(digit_strobe), 1);
    chk("min_digit", 32'(digit), 2);
    cyc(9);
    chk("d3_digit", 32'(digit), 3);
    chk("d3_seq", 32'(seq_error), 0);
    hold(7'h7D, 7);
    chk("skip_digit", 32'(digit), 6);
    chk("skip_seq", 32'(seq_error), 1);
    hold(7'h07, 7);
    chk("sticky_seq", 32'(seq_error), 1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_seq", 32'(seq_error), 0);
    hold(7'h66, 5);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_coinc_strobe", 32'(digit_strobe), 1);
    chk("clr_coinc_seq", 32'(seq_error), 1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    hold(7'h6D, 7);
    hold(7'h7D, 7);
    hold(7'h07, 7);
    hold(7'h7F, 7);
    hold(7'h6F, 7);
    chk("d9_digit", 32'(digit), 9);
    hold(7'h3F, 7);
    chk("wrap_digit", 32'(digit), 0);
    chk("wrap_seq", 32'(seq_error), 0);
    hold(7'h00, 7);
    chk("blank_blank", 32'(blank), 1);
    chk("blank_valid", 32'(digit_valid), 0);
    chk("blank_digit", 32'(digit), 0);
    hold(7'h4F, 7);
    chk("post_blank_digit", 32'(digit), 3);
    chk("post_blank_seq", 32'(seq_error), 0);
    chk("post_blank_blank", 32'(blank), 0);
    hold(7'h01, 7);
    chk("bad_flag", 32'(bad_pattern), 1);
    chk("bad_valid", 32'(digit_valid), 0);
    chk("bad_digit", 32'(digit), 3);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_bad", 32'(bad_pattern), 0);
    hold(7'h66, 7);
    hold(7'h6D, 7);
    chk("pre_rst_digit", 32'(digit), 5);
    chk("pre_rst_seq", 32'(seq_error), 0);
    rst_n = 1'b0;
    hold(7'h07, 1);
    chk("mid_rst_digit", 32'(digit), 0);
    chk("mid_rst_valid", 32'(digit_valid), 0);
    chk("mid_rst_strobe", 32'(digit_strobe), 0);
    chk("mid_rst_period", 32'(period), 0);
    rst_n = 1'b1;
    cyc(6);
    chk("d7_strobe", 32'(digit_strobe), 1);
    chk("d7_digit", 32'(digit), 7);
    chk("d7_seq", 32'(seq_error), 0);
    chk("d7_period", 32'(period), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
